// File: rtl/scale_line_sequencer_if.sv
// Bus bundle for scale_line_sequencer.
// Slave is the sequencer; master is its driver.
interface scale_line_sequencer_if #(
    parameter int PIX_WIDTH = 16,
    parameter int FIX_LEN   = 15,
    parameter int POS_W     = 11
);
    logic                 frame_start;
    logic [FIX_LEN-1:0]   x_scale;
    logic [FIX_LEN-1:0]   y_scale;
    logic [POS_W-1:0]     target_h;
    logic [POS_W-1:0]     target_v;
    logic                 tran_done;
    logic [PIX_WIDTH-1:0] input_data;
    logic                 wr_req;
    logic [POS_W-1:0]     dst_row;
    logic [POS_W-1:0]     x_pos;
    logic [PIX_WIDTH-1:0] out_data;
    logic                 data_valid;
    logic                 row_done;
    logic                 frame_done;
    logic                 busy;

    modport slave (
        input  frame_start, x_scale, y_scale,
        input  target_h, target_v,
        input  tran_done, input_data,
        output wr_req, dst_row, x_pos,
        output out_data, data_valid,
        output row_done, frame_done, busy
    );

    modport master (
        output frame_start, x_scale, y_scale,
        output target_h, target_v,
        output tran_done, input_data,
        input  wr_req, dst_row, x_pos,
        input  out_data, data_valid,
        input  row_done, frame_done, busy
    );
endinterface

// File: rtl/scale_line_sequencer.sv
// Line sequencer for a scaled image centred in a fixed
// output frame: fetches source lines, pads borders.
module scale_line_sequencer #(
    parameter int PIX_WIDTH = 16,
    parameter int FIX_LEN   = 15,
    parameter int FLOAT_LEN = 11,
    parameter int POS_W     = 11,
    parameter int OUT_H     = 640,
    parameter int OUT_V     = 720,
    parameter int PIPE_LAT  = 2,
    parameter logic [PIX_WIDTH-1:0] PAD_VALUE = '0
) (
    input logic clk,
    input logic rstn,
    scale_line_sequencer_if.slave bus
);

    localparam int EW = POS_W + 1;
    typedef logic [EW-1:0] ext_t;

    localparam ext_t OUT_H_E = ext_t'(OUT_H);
    localparam ext_t OUT_V_E = ext_t'(OUT_V);
    localparam logic [FIX_LEN-1:0] ONE_FIX =
        FIX_LEN'(1) << FLOAT_LEN;
    localparam logic [POS_W-1:0] C_LAST = POS_W'(OUT_H - 1);
    localparam logic [POS_W-1:0] R_LAST = POS_W'(OUT_V - 1);
    localparam logic [POS_W-1:0] D_LAST = POS_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, REQ, RUN, DRAIN, ROW_END, FRAME_DONE
    } state_t;

    state_t state_q, state_d;
    logic [POS_W-1:0] r_q, r_d;
    logic [POS_W-1:0] c_q, c_d;
    logic cfg_load;

    logic h_up_q, h_up_d, v_up_q, v_up_d;
    ext_t h_pad_q, h_pad_d, v_pad_q, v_pad_d;
    ext_t h_off_q, h_off_d, v_off_q, v_off_d;
    ext_t h_len_q, h_len_d, v_len_q, v_len_d;

    logic h_up_n, v_up_n;
    ext_t h_pad_n, v_pad_n, h_off_n, v_off_n;
    ext_t tgt_h_e, tgt_v_e;

    logic [PIPE_LAT-1:0] vld_q, vld_d;
    logic [PIPE_LAT-1:0] pad_q, pad_d;

    logic col_act, row_act, run_c;
    ext_t c_e, r_e, x_addr, y_addr;

    // Decode a new configuration: mode and centring offsets
    always_comb begin
        tgt_h_e = ext_t'(bus.target_h);
        tgt_v_e = ext_t'(bus.target_v);
        h_up_n  = bus.x_scale >= ONE_FIX;
        v_up_n  = bus.y_scale >= ONE_FIX;
        h_pad_n = '0;
        v_pad_n = '0;
        h_off_n = '0;
        v_off_n = '0;
        if (!h_up_n && OUT_H_E > tgt_h_e)
            h_pad_n = (OUT_H_E - tgt_h_e) >> 1;
        if (h_up_n && tgt_h_e > OUT_H_E)
            h_off_n = (tgt_h_e - OUT_H_E) >> 1;
        if (!v_up_n && OUT_V_E > tgt_v_e)
            v_pad_n = (OUT_V_E - tgt_v_e) >> 1;
        if (v_up_n && tgt_v_e > OUT_V_E)
            v_off_n = (tgt_v_e - OUT_V_E) >> 1;
    end

    // Hold configuration until the next frame start
    always_comb begin
        h_up_d  = h_up_q;
        v_up_d  = v_up_q;
        h_pad_d = h_pad_q;
        v_pad_d = v_pad_q;
        h_off_d = h_off_q;
        v_off_d = v_off_q;
        h_len_d = h_len_q;
        v_len_d = v_len_q;
        if (cfg_load) begin
            h_up_d  = h_up_n;
            v_up_d  = v_up_n;
            h_pad_d = h_pad_n;
            v_pad_d = v_pad_n;
            h_off_d = h_off_n;
            v_off_d = v_off_n;
            h_len_d = tgt_h_e;
            v_len_d = tgt_v_e;
        end
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_up_q  <= 1'b0;
            v_up_q  <= 1'b0;
            h_pad_q <= '0;
            v_pad_q <= '0;
            h_off_q <= '0;
            v_off_q <= '0;
            h_len_q <= '0;
            v_len_q <= '0;
        end else begin
            h_up_q  <= h_up_d;
            v_up_q  <= v_up_d;
            h_pad_q <= h_pad_d;
            v_pad_q <= v_pad_d;
            h_off_q <= h_off_d;
            v_off_q <= v_off_d;
            h_len_q <= h_len_d;
            v_len_q <= v_len_d;
        end
    end

    // Active-window test and source addresses for r/c
    always_comb begin
        c_e     = ext_t'(c_q);
        r_e     = ext_t'(r_q);
        col_act = h_up_q ||
                  (c_e >= h_pad_q && c_e < h_pad_q + h_len_q);
        row_act = v_up_q ||
                  (r_e >= v_pad_q && r_e < v_pad_q + v_len_q);
        x_addr  = h_up_q ? c_e + h_off_q : c_e - h_pad_q;
        y_addr  = v_up_q ? r_e + v_off_q : r_e - v_pad_q;
    end

    // Next-state, row and column counters
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        c_d      = c_q;
        cfg_load = 1'b0;
        unique case (state_q)
            IDLE, FRAME_DONE: begin
                if (bus.frame_start) begin
                    cfg_load = 1'b1;
                    r_d      = '0;
                    c_d      = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                c_d     = '0;
                state_d = row_act ? REQ : RUN;
            end
            REQ: begin
                if (bus.tran_done)
                    state_d = RUN;
            end
            RUN: begin
                if (c_q == C_LAST) begin
                    c_d     = '0;
                    state_d = DRAIN;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            DRAIN: begin
                if (c_q == D_LAST) begin
                    c_d     = '0;
                    state_d = ROW_END;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            ROW_END: begin
                if (r_q == R_LAST) begin
                    state_d = FRAME_DONE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = SETUP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    // Delay valid and pad flags to meet returning data
    always_comb begin
        run_c    = state_q == RUN;
        vld_d    = vld_q << 1;
        pad_d    = pad_q << 1;
        vld_d[0] = run_c;
        pad_d[0] = run_c && !(col_act && row_act);
    end

    // Alignment pipeline
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
            pad_q <= '0;
        end else begin
            vld_q <= vld_d;
            pad_q <= pad_d;
        end
    end

    // Output decode
    always_comb begin
        bus.wr_req     = state_q == REQ;
        bus.row_done   = state_q == ROW_END;
        bus.frame_done = state_q == FRAME_DONE;
        bus.busy       = state_q != IDLE &&
                         state_q != FRAME_DONE;
        bus.dst_row    = y_addr[POS_W-1:0];
        bus.x_pos      = '0;
        if (run_c && col_act && row_act)
            bus.x_pos = x_addr[POS_W-1:0];
        bus.data_valid = vld_q[PIPE_LAT-1];
        bus.out_data   = '0;
        if (vld_q[PIPE_LAT-1])
            bus.out_data = pad_q[PIPE_LAT-1] ?
                           PAD_VALUE : bus.input_data;
    end

endmodule

// File: tb/tb_scale_line_sequencer.sv
// Scoreboard bench for scale_line_sequencer on a
// reduced 16x12 frame with directed configurations.
module tb_scale_line_sequencer;

    localparam int PW   = 16;
    localparam int FL   = 15;
    localparam int FLT  = 11;
    localparam int POSW = 11;
    localparam int OH   = 16;
    localparam int OV   = 12;
    localparam int PL   = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    scale_line_sequencer_if #(
        .PIX_WIDTH(PW), .FIX_LEN(FL), .POS_W(POSW)
    ) bus ();

    scale_line_sequencer #(
        .PIX_WIDTH(PW), .FIX_LEN(FL), .FLOAT_LEN(FLT),
        .POS_W(POSW), .OUT_H(OH), .OUT_V(OV),
        .PIPE_LAT(PL), .PAD_VALUE(16'h0000)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    // Line-buffer model: data tagged with row and address,
    // returned PL=2 cycles after x_pos
    logic [POSW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= bus.x_pos;
        a2 <= a1;
    end
    assign bus.input_data = {bus.dst_row[7:0], a2[7:0]};

    logic [PW-1:0]   px_q[$];
    logic [POSW-1:0] rq_q[$];

    int checks = 0;
    int errors = 0;
    int npix   = 0;
    int nrow   = 0;
    int td_delay = 1;
    bit spur_en  = 1'b0;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Expected frame from hand-derived active windows
    task automatic push_frame(int ca, int cb, int x0,
                              int ra, int rb, int d0);
        for (int r = 0; r < OV; r++) begin
            bit ract = (r >= ra) && (r <= rb);
            logic [7:0] dr = 8'(d0 + r - ra);
            if (ract) rq_q.push_back(POSW'(d0 + r - ra));
            for (int c = 0; c < OH; c++) begin
                logic [7:0] xv = 8'(x0 + c - ca);
                if (ract && c >= ca && c <= cb)
                    px_q.push_back({dr, xv});
                else
                    px_q.push_back(16'h0000);
            end
        end
    endtask

    // Monitor: pixels, requests, latency, row framing
    int  vrun = 0;
    int  lat  = 0;
    bit  armed = 1'b0;
    bit  prev_wr = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            vrun = 0;
            armed = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (bus.data_valid) begin
                if (px_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data %0h expected none",
                             bus.out_data);
                end else begin
                    chk("pixel", 32'(bus.out_data),
                        32'(px_q.pop_front()));
                    npix++;
                end
                vrun++;
            end else if (vrun > 0) begin
                chk("valid_run_len", vrun, OH);
                chk("row_done_after_run", 32'(bus.row_done), 1);
                vrun = 0;
            end
            if (bus.row_done) nrow++;
            if (armed) begin
                lat++;
                if (bus.data_valid) begin
                    chk("first_valid_latency", lat, PL);
                    armed = 1'b0;
                end else if (lat > 10) begin
                    chk("first_valid_latency", lat, PL);
                    armed = 1'b0;
                end
            end
            if (prev_wr && !bus.wr_req) begin
                armed = 1'b1;
                lat = 0;
            end
            if (bus.wr_req && !prev_wr) begin
                if (rq_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got dst_row %0d expected none",
                             bus.dst_row);
                end else begin
                    chk("dst_row", 32'(bus.dst_row),
                        32'(rq_q.pop_front()));
                end
            end
            prev_wr = bus.wr_req;
        end
    end

    // Responder: tran_done after td_delay request cycles,
    // plus an optional stray pulse while a row is running
    int wcnt = 0;
    logic [POSW-1:0] held;
    bit dv_prev = 1'b0;
    always @(negedge clk) begin
        bus.tran_done = 1'b0;
        if (!rstn) begin
            wcnt = 0;
        end else if (bus.wr_req) begin
            if (wcnt == 0) held = bus.dst_row;
            else chk("dst_row_stable", 32'(bus.dst_row), 32'(held));
            wcnt++;
            if (wcnt == td_delay) bus.tran_done = 1'b1;
        end else begin
            if (wcnt > 0) chk("wr_req_hold", wcnt, td_delay);
            wcnt = 0;
            if (spur_en && bus.data_valid && !dv_prev)
                bus.tran_done = 1'b1;
        end
        dv_prev = bus.data_valid;
    end

    task automatic start_frame(logic [FL-1:0] xs,
                               logic [FL-1:0] ys,
                               int th, int tv, bit garble);
        @(negedge clk);
        bus.x_scale  = xs;
        bus.y_scale  = ys;
        bus.target_h = POSW'(th);
        bus.target_v = POSW'(tv);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("frame_done_cleared", 32'(bus.frame_done), 0);
        if (garble) begin
            bus.x_scale  = 15'h7fff;
            bus.y_scale  = 15'h7fff;
            bus.target_h = 11'd3;
            bus.target_v = 11'd1000;
        end
    endtask

    task automatic finish_frame(string tag);
        int i;
        for (i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (bus.frame_done) break;
        end
        if (i == 20000) begin
            $display("FAIL %s_timeout: got no frame_done expected frame_done=1",
                     tag);
            errors++;
            checks++;
            $display("Simulation finished: %0d checks, %0d errors",
                     checks, errors);
            $fatal(1, "frame timeout");
        end
        chk({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        chk({tag, "_row_done_count"}, nrow, OV);
        chk({tag, "_pixels_left"}, px_q.size(), 0);
        chk({tag, "_reqs_left"}, rq_q.size(), 0);
    endtask

    task automatic run_frame(string tag, logic [FL-1:0] xs,
                             logic [FL-1:0] ys, int th, int tv,
                             int dly, bit spur, bit garble,
                             int ca, int cb, int x0,
                             int ra, int rb, int d0);
        td_delay = dly;
        spur_en  = spur;
        nrow     = 0;
        push_frame(ca, cb, x0, ra, rb, d0);
        start_frame(xs, ys, th, tv, garble);
        finish_frame(tag);
    endtask

    task automatic chk_idle_outputs(string tag);
        chk({tag, "_wr_req"}, 32'(bus.wr_req), 0);
        chk({tag, "_dst_row"}, 32'(bus.dst_row), 0);
        chk({tag, "_x_pos"}, 32'(bus.x_pos), 0);
        chk({tag, "_out_data"}, 32'(bus.out_data), 0);
        chk({tag, "_data_valid"}, 32'(bus.data_valid), 0);
        chk({tag, "_row_done"}, 32'(bus.row_done), 0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.x_scale  = '0;
        bus.y_scale  = '0;
        bus.target_h = '0;
        bus.target_v = '0;
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Down: 12x8 in 16x12 -> pad cols 0-1,14-15,
        // pad rows 0-1,10-11; config changed mid-frame
        run_frame("down", 15'h0400, 15'h0400, 12, 8,
                  1, 1'b0, 1'b1, 2, 13, 0, 2, 9, 0);

        // Up: 20x18 -> x_pos 2..17, dst_row from 3;
        // slow fetch and stray tran_done in RUN
        run_frame("up", 15'h0c00, 15'h0c00, 20, 18,
                  50, 1'b1, 1'b0, 0, 15, 2, 0, 11, 3);

        // Down, target_h == OUT_H (no column pad),
        // odd vertical margin: pad_t=1, rows 1..9
        run_frame("down_edge", 15'h0200, 15'h0200, 16, 9,
                  3, 1'b0, 1'b0, 0, 15, 0, 1, 9, 0);

        // Up with targets not above the frame: zero offset
        run_frame("up_edge", 15'h0800, 15'h0800, 10, 12,
                  2, 1'b0, 1'b0, 0, 15, 0, 0, 11, 0);

        // Reset in the middle of the first active row
        td_delay = 1;
        spur_en  = 1'b0;
        nrow     = 0;
        npix     = 0;
        push_frame(2, 13, 0, 2, 9, 0);
        start_frame(15'h0400, 15'h0400, 12, 8, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            if (npix >= 40) break;
            @(negedge clk);
        end
        chk("abort_reached_column", npix, 40);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rstn = 1'b1;
        px_q.delete();
        rq_q.delete();
        repeat (30) @(negedge clk);
        chk("abort_stays_idle", 32'(bus.busy), 0);
        chk("abort_no_frame_done", 32'(bus.frame_done), 0);

        // A fresh frame after the abort
        run_frame("recover", 15'h0800, 15'h0800, 10, 12,
                  1, 1'b0, 1'b0, 0, 15, 0, 0, 11, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
